// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// registers {instruction, instr_pc} for the decoder. Optional macro: IFETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ill_instr,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a word transfers on the rising edge where imem_req=1 and
  // imem_ready=1; imem_rdata is valid in that same cycle. imem_req/imem_addr are
  // held until ready unless a redirect or reset aborts the request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        live;
  logic        halt_now;
  logic        xfer;
  logic        misalign;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign = (branch_target[1:0] != 2'b00);
`else
  logic unused_tgt_bits;
  assign misalign        = 1'b0;
  assign unused_tgt_bits = ^branch_target[1:0];
`endif

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign fsm_state = state;

  always_comb begin
    live      = (state == FETCH) || (state == STALL);
    halt_now  = live && instr_valid && ill_instr && !stall && !branch_taken;
    imem_req  = 1'b0;
    // A live instruction under stall must not be overwritten, so no request;
    // leaving STALL requests pc in the first cycle stall drops.
    if (!branch_taken && !halt_now) begin
      if (state == FETCH)      imem_req = !(stall && instr_valid);
      else if (state == STALL) imem_req = !stall;
    end
    xfer      = imem_req && imem_ready;

    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (stall && instr_valid) state_nxt = STALL;
      STALL:   if (!stall) state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
    if (state != HALT) begin
      if (branch_taken)  state_nxt = misalign ? HALT : FETCH;
      else if (halt_now) state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != HALT) begin
        if (branch_taken) begin
          instr_valid <= 1'b0;
          instruction <= NOP_INSTR;
          if (!misalign) pc <= {branch_target[31:2], 2'b00};
        end else if (halt_now) begin
          instr_valid <= 1'b0;
        end else if (xfer) begin
          instruction <= imem_rdata;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + 32'd4;
        end else if (!stall) begin
          // Current word was consumed and nothing new arrived.
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ill_instr;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halted, m_bubble;

  instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ill_instr(ill_instr),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- reference model ----------------
  function automatic logic exp_req();
    return !m_halted && !m_bubble && !branch_taken
           && !(m_valid && stall) && !(m_valid && ill_instr && !stall);
  endfunction

  function automatic logic [98:0] exp_vec();
    logic r;
    r = exp_req();
    return {r, r ? m_pc : 32'h0, m_valid, m_instr, m_ipc, m_halted};
  endfunction

  function automatic logic [98:0] obs_vec();
    return {imem_req, imem_req ? imem_addr : 32'h0, instr_valid, instruction, instr_pc, halted};
  endfunction

  // Advances the model by one clock using the inputs currently applied, then
  // lets the DUT see the same edge; returns just after the falling edge.
  task automatic tick();
    logic r;
    r = exp_req();
    if (reset) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = RESET_PC;
      m_valid = 1'b0; m_halted = 1'b0; m_bubble = 1'b1;
    end else if (!m_halted) begin
      if (branch_taken) begin
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (branch_target[1:0] != 2'b00) m_halted = 1'b1;
        else m_pc = branch_target;
`else
        m_pc = branch_target & ~32'd3;
`endif
      end else if (m_valid && ill_instr && !stall) begin
        m_valid  = 1'b0;
        m_halted = 1'b1;
      end else if (r && imem_ready) begin
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
      m_bubble = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; ill_instr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    imem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if ({imem_req, instr_valid, halted, instruction, instr_pc} !== {1'b0, 1'b0, 1'b0, NOP_INSTR, RESET_PC}) begin
      bad++;
      $display("FAIL reset_values: actual req=%0b v=%0b h=%0b ins=%h pc=%h required 0 0 0 %h %h",
               imem_req, instr_valid, halted, instruction, instr_pc, NOP_INSTR, RESET_PC);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model: actual=%h required=%h", obs_vec(), exp_vec());
    end
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL reset_bubble: actual req=%0b required 0", imem_req);
    end
    tick();
  endtask

  task automatic test_throughput();
    logic [31:0] e;
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL stream c%0d: actual=%h required=%h", c, obs_vec(), exp_vec());
      end
      if (imem_req) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        total++;
        if (imem_addr !== e) begin
          bad++; $display("FAIL stream_addr c%0d: actual=%h required=%h", c, imem_addr, e);
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL stream_count: actual left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ready_gap();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && m_pc != 32'h8; i++) begin
      #1; total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL gap_pre: actual=%h required=%h", obs_vec(), exp_vec());
      end
      tick();
    end
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (obs_vec() !== exp_vec() || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        bad++; $display("FAIL gap_wait%0d: actual=%h required=%h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    imem_ready = 1'b1;
    #1; total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL gap_ready: actual=%h required=%h", obs_vec(), exp_vec());
    end
    tick();
    #1; total++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'h0050_0093, 32'h8}) begin
      bad++; $display("FAIL gap_word: actual v=%0b ins=%h pc=%h required 1 00500093 00000008",
                      instr_valid, instruction, instr_pc);
    end
    // reset while a request is waiting must drop it
    imem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    #1; total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL reset_abort: actual req=%0b required 0", imem_req);
    end
    reset = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !(m_valid && m_ipc == 32'h4); i++) begin
      #1; total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL stall_pre: actual=%h required=%h", obs_vec(), exp_vec());
      end
      tick();
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; total++;
      if (obs_vec() !== exp_vec() || imem_req !== 1'b0 || instr_pc !== 32'h4) begin
        bad++; $display("FAIL stall_hold%0d: actual=%h required=%h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    stall = 1'b0;
    #1; total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL stall_resume: actual req=%0b addr=%h required 1 00000008", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    imem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20 && m_pc != (k == 0 ? 32'hC : 32'h10C); i++) begin
        #1; total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL br_pre%0d: actual=%h required=%h", k, obs_vec(), exp_vec());
        end
        tick();
      end
      branch_taken = 1'b1; branch_target = 32'h100; stall = (k == 1);
      #1; total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL br_edge%0d: actual=%h required=%h", k, obs_vec(), exp_vec());
      end
      tick();
      branch_taken = 1'b0;
      #1; total++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
        bad++; $display("FAIL br_target%0d: actual v=%0b req=%0b addr=%h required 0 1 00000100",
                        k, instr_valid, imem_req, imem_addr);
      end
      tick();
      stall = 1'b0;
    end
    // misaligned redirect
    branch_taken = 1'b1; branch_target = 32'h102;
    tick();
    branch_taken = 1'b0;
    #1; total++;
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL br_misalign: actual h=%0b req=%0b required 1 0", halted, imem_req);
    end
`else
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || halted !== 1'b0) begin
      bad++; $display("FAIL br_misalign: actual req=%0b addr=%h h=%0b required 1 00000100 0",
                      imem_req, imem_addr, halted);
    end
`endif
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    imem_ready = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    tick();
    branch_taken = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
    for (int c = 0; c < 4; c++) begin
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== e || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL wrap c%0d: actual req=%0b addr=%h required 1 %h", c, imem_req, imem_addr, e);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !(m_valid && m_ipc == 32'h10); i++) begin
      #1; total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL ill_pre: actual=%h required=%h", obs_vec(), exp_vec());
      end
      tick();
    end
    ill_instr = 1'b1;
    #1; total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL ill_edge: actual=%h required=%h", obs_vec(), exp_vec());
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      branch_taken = (i == 2); branch_target = 32'h200;
      #1; total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL ill_halt%0d: actual h=%0b req=%0b v=%0b required 1 0 0",
                        i, halted, imem_req, instr_valid);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1; total++;
    if (imem_addr !== RESET_PC || halted !== 1'b0) begin
      bad++; $display("FAIL ill_reset: actual addr=%h h=%0b required %h 0", imem_addr, halted, RESET_PC);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 63) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 1) == 0) branch_target[1:0] = 2'b00;
      ill_instr     = ($urandom_range(0, 24) == 0);
      #1; total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand c%0d: actual=%h required=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = RESET_PC;
    m_valid = 1'b0; m_halted = 1'b0; m_bubble = 1'b1;
    @(negedge clk);
    test_reset();
    test_throughput();
    test_ready_gap();
    test_stall();
    test_branch();
    test_wrap();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
